// File: rtl/fetch_redirect_unit.sv
// Purpose : owns the fetch PC, selects the next PC, carries PC/hit/target through IF/ID and ID/EX, flushes on mispredict.
// Latency : fetch PC reaches EX after 2 cycles; a redirect corrects pc_o 1 cycle later (3 cycles to reach EX).
// Backpressure: stall_i holds pc_o and IF/ID and drops a bubble into ID/EX; a redirect overrides stall_i.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   stall_i                   hazard-unit stall
//   hit_i, predicted_pc_i     predictor lookup result for the current pc_o
//   wrong_predicted_i         EX verdict (00 ok, 01 taken-not-taken, 1x not-predicted-taken)
//   alu_pc_i                  resolved branch/jump target from EX
//   pc_o                      fetch PC (imem address, predictor lookup)
//   pc_id_o, valid_id_o       ID slot
//   pc_ex_o, hit_ex_o, valid_ex_o  EX slot (fed back to the predictor)
//   flush_o                   combinational kill of IF/ID and ID/EX
//   mispredict_cnt_o          saturating count of redirects
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             hit_i,
    input  logic [31:0]      predicted_pc_i,
    input  logic [1:0]       wrong_predicted_i,
    input  logic [31:0]      alu_pc_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_id_o,
    output logic             valid_id_o,
    output logic [31:0]      pc_ex_o,
    output logic             hit_ex_o,
    output logic             valid_ex_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      pc;
    logic [31:0]      pc_id;
    logic             hit_id;
    logic [31:0]      tgt_id;
    logic             valid_id;
    logic [31:0]      pc_ex;
    logic             hit_ex;
    logic [31:0]      tgt_ex;
    logic             valid_ex;
    logic [CNT_W-1:0] cnt;

    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      pc_nxt;

    // Redirect decision, next-PC selection and next state.
    always_comb begin
        state_nxt   = state;
        redirect    = 1'b0;
        redirect_pc = alu_pc_i;
        pc_nxt      = pc + 32'd4;

        // A verdict only counts when EX really holds an instruction; a hit
        // whose carried target disagrees with the resolved one (e.g. JALR)
        // is a mispredict even when the direction was right.
        if (valid_ex) begin
            if (wrong_predicted_i != 2'b00) begin
                redirect = 1'b1;
            end else if (hit_ex && (tgt_ex != alu_pc_i)) begin
                redirect = 1'b1;
            end
        end

        if (wrong_predicted_i == 2'b01) begin
            redirect_pc = pc_ex + 32'd4;
        end

        if (redirect) begin
            pc_nxt = redirect_pc;
        end else if (stall_i) begin
            pc_nxt = pc;
        end else if (hit_i) begin
            pc_nxt = predicted_pc_i;
        end

        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = redirect ? RECOVER : RUN;
            RECOVER: state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_id    <= '0;
            hit_id   <= 1'b0;
            tgt_id   <= '0;
            valid_id <= 1'b0;
            pc_ex    <= '0;
            hit_ex   <= 1'b0;
            tgt_ex   <= '0;
            valid_ex <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redirect) begin
                valid_id <= 1'b0;
                hit_id   <= 1'b0;
                valid_ex <= 1'b0;
                hit_ex   <= 1'b0;
                if (cnt != {CNT_W{1'b1}}) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (stall_i) begin
                // IF/ID holds; EX receives a bubble but keeps its PC.
                valid_ex <= 1'b0;
                hit_ex   <= 1'b0;
            end else begin
                pc_id    <= pc;
                hit_id   <= hit_i;
                tgt_id   <= predicted_pc_i;
                valid_id <= (state != BOOT);
                pc_ex    <= pc_id;
                // Masked so an invalid slot never reports a hit.
                hit_ex   <= hit_id & valid_id;
                tgt_ex   <= tgt_id;
                valid_ex <= valid_id;
            end
        end
    end

    assign pc_o             = pc;
    assign pc_id_o          = pc_id;
    assign valid_id_o       = valid_id;
    assign pc_ex_o          = pc_ex;
    assign hit_ex_o         = hit_ex;
    assign valid_ex_o       = valid_ex;
    assign flush_o          = redirect;
    assign mispredict_cnt_o = cnt;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Purpose : directed self-checking bench for fetch_redirect_unit.
// Latency : inputs driven 1 time unit after each rising edge; registered outputs checked there too.
// Backpressure: exercises stall_i holds, stale verdicts, redirect-over-stall and reset mid-redirect.
module tb_fetch_redirect_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        hit;
    logic [31:0] pred;
    logic [1:0]  wp;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic        valid_id;
    logic [31:0] pc_ex;
    logic        hit_ex;
    logic        valid_ex;
    logic        flush;
    logic [31:0] cnt;

    int passed = 0;
    int total  = 0;

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .hit_i             (hit),
        .predicted_pc_i    (pred),
        .wrong_predicted_i (wp),
        .alu_pc_i          (alu),
        .pc_o              (pc),
        .pc_id_o           (pc_id),
        .valid_id_o        (valid_id),
        .pc_ex_o           (pc_ex),
        .hit_ex_o          (hit_ex),
        .valid_ex_o        (valid_ex),
        .flush_o           (flush),
        .mispredict_cnt_o  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        hit   = 1'b0;
        pred  = 32'h0;
        wp    = 2'b00;
        alu   = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_pc",       pc,       32'h0);
        chk("rst_pc_id",    pc_id,    32'h0);
        chk("rst_valid_id", {31'b0, valid_id}, 32'h0);
        chk("rst_pc_ex",    pc_ex,    32'h0);
        chk("rst_hit_ex",   {31'b0, hit_ex},   32'h0);
        chk("rst_valid_ex", {31'b0, valid_ex}, 32'h0);
        chk("rst_flush",    {31'b0, flush},    32'h0);
        chk("rst_cnt",      cnt,      32'h0);

        // 1: free run from reset
        rst = 1'b0;
        tick();
        chk("t1_pc_e1",       pc,                32'h4);
        chk("t1_valid_id_e1", {31'b0, valid_id}, 32'h0);
        tick();
        chk("t1_pc_e2",       pc,                32'h8);
        chk("t1_valid_id_e2", {31'b0, valid_id}, 32'h1);
        chk("t1_pc_id_e2",    pc_id,             32'h4);
        chk("t1_valid_ex_e2", {31'b0, valid_ex}, 32'h0);
        tick();
        chk("t1_pc_e3",       pc,                32'hC);
        chk("t1_valid_ex_e3", {31'b0, valid_ex}, 32'h1);
        chk("t1_pc_ex_e3",    pc_ex,             32'h4);
        chk("t1_flush",       {31'b0, flush},    32'h0);
        tick();
        chk("t1_pc_e4",       pc,                32'h10);

        // 2: predicted-taken fetch at 0x10
        hit  = 1'b1;
        pred = 32'h80;
        tick();
        chk("t2_pc_pred",  pc,    32'h80);
        chk("t2_pc_id",    pc_id, 32'h10);
        hit = 1'b0;
        tick();
        chk("t2_pc_seq",   pc,               32'h84);
        chk("t2_pc_ex",    pc_ex,            32'h10);
        chk("t2_hit_ex",   {31'b0, hit_ex},  32'h1);
        chk("t2_valid_ex", {31'b0, valid_ex}, 32'h1);

        // 3: predicted taken but not taken -> pc_ex+4
        wp = 2'b01;
        #1;
        chk("t3_flush", {31'b0, flush}, 32'h1);
        tick();
        chk("t3_pc",       pc,                32'h14);
        chk("t3_valid_id", {31'b0, valid_id}, 32'h0);
        chk("t3_valid_ex", {31'b0, valid_ex}, 32'h0);
        chk("t3_hit_ex",   {31'b0, hit_ex},   32'h0);
        chk("t3_cnt",      cnt,               32'h1);
        wp = 2'b00;
        #1;
        chk("t3_no_flush_invalid_ex", {31'b0, flush}, 32'h0);
        tick();
        tick();
        chk("t3_refill_pc_ex", pc_ex, 32'h14);
        chk("t3_refill_pc",    pc,    32'h1C);

        // 4: redirect wins over a simultaneous stall
        wp    = 2'b10;
        alu   = 32'h200;
        stall = 1'b1;
        #1;
        chk("t4_flush", {31'b0, flush}, 32'h1);
        tick();
        chk("t4_pc",       pc,                32'h200);
        chk("t4_cnt",      cnt,               32'h2);
        chk("t4_valid_ex", {31'b0, valid_ex}, 32'h0);
        wp    = 2'b00;
        stall = 1'b0;
        alu   = 32'h0;

        // 5: hit with wrong target (0x80 vs 0x90) redirects to alu_pc
        hit  = 1'b1;
        pred = 32'h80;
        tick();
        chk("t5_pc_pred", pc, 32'h80);
        hit = 1'b0;
        tick();
        chk("t5_pc_ex",  pc_ex,           32'h200);
        chk("t5_hit_ex", {31'b0, hit_ex}, 32'h1);
        alu = 32'h90;
        #1;
        chk("t5_flush_mismatch", {31'b0, flush}, 32'h1);
        tick();
        chk("t5_pc_redirect", pc,  32'h90);
        chk("t5_cnt",         cnt, 32'h3);
        // Same again but the target matches: no redirect
        hit  = 1'b1;
        pred = 32'h80;
        tick();
        hit = 1'b0;
        tick();
        chk("t5b_pc_ex",  pc_ex,           32'h90);
        chk("t5b_hit_ex", {31'b0, hit_ex}, 32'h1);
        alu = 32'h80;
        #1;
        chk("t5b_no_flush", {31'b0, flush}, 32'h0);
        tick();
        chk("t5b_pc",       pc,                32'h88);
        chk("t5b_cnt",      cnt,               32'h3);
        chk("t5b_valid_ex", {31'b0, valid_ex}, 32'h1);

        // 6: redirect to 0x1C, advance once, then stall 3 cycles at 0x20
        wp  = 2'b10;
        alu = 32'h1C;
        #1;
        chk("t6_setup_flush", {31'b0, flush}, 32'h1);
        tick();
        chk("t6_setup_pc",  pc,  32'h1C);
        chk("t6_setup_cnt", cnt, 32'h4);
        wp = 2'b00;
        tick();
        chk("t6_pc_start",    pc,                32'h20);
        chk("t6_pc_id_start", pc_id,             32'h1C);
        chk("t6_valid_ex0",   {31'b0, valid_ex}, 32'h0);
        stall = 1'b1;
        wp    = 2'b10;
        alu   = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_stale_flush_%0d", i), {31'b0, flush}, 32'h0);
            tick();
            chk($sformatf("t6_pc_hold_%0d", i),    pc,                32'h20);
            chk($sformatf("t6_pc_id_hold_%0d", i), pc_id,             32'h1C);
            chk($sformatf("t6_valid_ex_%0d", i),   {31'b0, valid_ex}, 32'h0);
            chk($sformatf("t6_cnt_%0d", i),        cnt,               32'h4);
        end
        stall = 1'b0;
        wp    = 2'b00;
        tick();
        chk("t6_release_pc",       pc,                32'h24);
        chk("t6_release_pc_id",    pc_id,             32'h20);
        chk("t6_release_pc_ex",    pc_ex,             32'h1C);
        chk("t6_release_valid_ex", {31'b0, valid_ex}, 32'h1);

        // Reset asserted together with a live redirect
        wp  = 2'b10;
        alu = 32'h300;
        rst = 1'b1;
        tick();
        chk("t7_pc",       pc,                32'h0);
        chk("t7_cnt",      cnt,               32'h0);
        chk("t7_valid_id", {31'b0, valid_id}, 32'h0);
        chk("t7_valid_ex", {31'b0, valid_ex}, 32'h0);
        chk("t7_flush",    {31'b0, flush},    32'h0);
        rst = 1'b0;
        wp  = 2'b00;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side PC owner sitting directly upstream of the branch predictor.
- Holds the architectural fetch PC and drives it to instruction memory and to the predictor lookup port.
- Chooses the next PC from the predictor hit/target, sequential PC+4, or an EX-stage redirect.
- Carries each fetch's PC, hit bit and predicted target down the IF/ID and ID/EX stages, so EX-stage verification gets hit_ex/pc_ex back. Raises pipeline flushes on mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- CNT_W, 32, width of the mispredict performance counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard-unit stall: hold PC and IF/ID, bubble into ID/EX.
- hit_i  in  1  predictor BTB hit for current pc_o.
- predicted_pc_i  in  32  predictor target for current pc_o.
- wrong_predicted_i  in  2  EX verdict: 00 ok, 01 predicted-taken-but-not-taken, 10/11 taken-but-not-predicted.
- alu_pc_i  in  32  resolved branch/jump target from EX.
- pc_o  out  32  current fetch PC (imem address, predictor pc_i).
- pc_id_o  out  32  PC of instruction in ID.
- valid_id_o  out  1  ID slot holds a live instruction.
- pc_ex_o  out  32  PC of instruction in EX (predictor pc_ex_i).
- hit_ex_o  out  1  hit bit of EX instruction (predictor hit_ex_i); 0 when EX invalid.
- valid_ex_o  out  1  EX slot holds a live instruction.
- flush_o  out  1  combinational: kill IF/ID and ID/EX contents this cycle.
- mispredict_cnt_o  out  CNT_W  count of redirects taken.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: pc_o=RESET_PC, all other outputs 0, FSM=BOOT. rst_i overrides every other input.
- FSM states:
  - BOOT: one cycle after reset deassert; IF/ID captures valid=0; goes to RUN.
  - RUN: normal operation.
  - RECOVER: the cycle after a redirect; behaves as RUN except EX is guaranteed invalid; goes to RUN.
  - RUN goes to RECOVER on redirect.
- Redirect condition (evaluated only when valid_ex_o=1):
  - wrong_predicted_i!=00, or
  - wrong_predicted_i==00 and hit_ex_o=1 and the predicted target carried in EX != alu_pc_i (target mismatch, e.g. JALR).
- Redirect target: code 01 gives pc_ex_o+4 (32-bit wrap); codes 10/11 or target mismatch give alu_pc_i.
- Next-PC priority: reset > redirect > stall_i > hit_i (predicted_pc_i) > pc_o+4 (mod 2^32).
- On redirect:
  - flush_o=1 in the same cycle.
  - Next edge: pc_o<=target, valid_id<=0, valid_ex<=0, hit_ex<=0.
  - Counter increments, saturating at all-ones.
  - Redirect overrides a simultaneous stall_i.
- On stall_i (no redirect):
  - pc_o and the IF/ID register (pc, hit, target, valid) hold.
  - ID/EX loads a bubble: valid_ex<=0, hit_ex<=0, pc_ex holds.
- Normal advance:
  - IF/ID <= {pc_o, hit_i, predicted_pc_i, valid = (state!=BOOT)}.
  - ID/EX <= IF/ID.
  - hit_ex_o is 0 whenever valid_ex_o=0.
- Latency:
  - Fetch PC to EX: 2 cycles.
  - Mispredict to correct pc_o: 1 cycle.
  - Mispredict to first correct instruction in EX: 3 cycles.
- wrong_predicted_i and alu_pc_i are ignored when valid_ex_o=0; a stale verdict never redirects.
- Reset asserted mid-redirect or mid-stall: reset values next edge, no counter update.

Test Plan:
1. Reset then free-run, hit_i=0, stall_i=0: pc_o goes 0,4,8,C. valid_id_o=1 from the second post-reset edge, valid_ex_o one cycle later. flush_o=0.
2. At pc_o=0x10 drive hit_i=1, predicted_pc_i=0x80: next pc_o=0x80. Two cycles later pc_ex_o=0x10 and hit_ex_o=1.
3. With EX pc_ex_o=0x10 and hit_ex_o=1, drive wrong_predicted_i=01: flush_o=1 same cycle, next pc_o=0x14, valid_id_o=valid_ex_o=0, mispredict_cnt_o=1.
4. With EX valid, drive wrong_predicted_i=10 and alu_pc_i=0x200 while stall_i=1: redirect wins. Next pc_o=0x200, counter+1, flush_o=1.
5. Target mismatch: EX holds hit_ex_o=1 with predicted target 0x80, wrong_predicted_i=00, alu_pc_i=0x90. Required: redirect to 0x90. Repeat with alu_pc_i=0x80: no flush.
6. Hold stall_i=1 for 3 cycles at pc_o=0x20: pc_o and pc_id_o hold, valid_ex_o=0 throughout. Drive wrong_predicted_i=10 while valid_ex_o=0: no redirect, counter unchanged.
